// File: rtl/stage_mem_pkg.sv
// mem_stage_pkg: shared encodings for the MIPS memory-access stage.
// Holds load/store width codes, write-back select codes, byte-lane masks
// and the load extension helper used by stage_mem.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } loadFlag_e;

  typedef enum logic [1:0] {
    ST_SW = 2'b00,
    ST_SH = 2'b01,
    ST_SB = 2'b10
  } storeFlag_e;

  typedef enum logic [1:0] {
    MTR_ALU  = 2'b00,
    MTR_MEM  = 2'b01,
    MTR_LINK = 2'b10
  } memtoReg_e;

  localparam logic [3:0] LANE_NONE    = 4'b0000;
  localparam logic [3:0] LANE_ALL     = 4'b1111;
  localparam logic [3:0] LANE_HALF_LO = 4'b0011;
  localparam logic [3:0] LANE_HALF_HI = 4'b1100;
  localparam logic [3:0] LANE_BYTE0   = 4'b0001;

  // Select the halfword/byte addressed by off and sign- or zero-extend it.
  // Codes 101-111 fall through to a full-word load.
  function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                             input logic [2:0]  flag,
                                             input logic [1:0]  off);
    logic [15:0] halfVal;
    logic [7:0]  byteVal;
    logic [31:0] result;
    halfVal = off[1] ? word[31:16] : word[15:0];
    case (off)
      2'b00:   byteVal = word[7:0];
      2'b01:   byteVal = word[15:8];
      2'b10:   byteVal = word[23:16];
      default: byteVal = word[31:24];
    endcase
    case (flag)
      LD_LH:   result = {{16{halfVal[15]}}, halfVal};
      LD_LHU:  result = {16'h0000, halfVal};
      LD_LB:   result = {{24{byteVal[7]}}, byteVal};
      LD_LBU:  result = {24'h000000, byteVal};
      default: result = word;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/stage_mem_mem_wb_latch.sv
// mem_wb_latch: MEM/WB pipeline register bank.
// Synchronous active-high reset clears every field; enable=0 holds.
// With MEM_ALIGN_CHECK_EN defined a misaligned flag is carried as well.
module mem_wb_latch (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] inMemData,
  input  logic [31:0] inAlu,
  input  logic [4:0]  inMuxRtRd,
  input  logic [1:0]  inMemtoReg,
  input  logic        inRegWrite,
  output logic [31:0] outMemData,
  output logic [31:0] outAlu,
  output logic [4:0]  outMuxRtRd,
  output logic [1:0]  outMemtoReg,
  output logic        outRegWrite
`ifdef MEM_ALIGN_CHECK_EN
  ,
  input  logic        inMisaligned,
  output logic        outMisaligned
`endif
);

  // Pipeline register: reset wins over enable, enable=0 holds the contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      outMemData  <= 32'h0000_0000;
      outAlu      <= 32'h0000_0000;
      outMuxRtRd  <= 5'd0;
      outMemtoReg <= 2'b00;
      outRegWrite <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      outMisaligned <= 1'b0;
`endif
    end else if (enable) begin
      outMemData  <= inMemData;
      outAlu      <= inAlu;
      outMuxRtRd  <= inMuxRtRd;
      outMemtoReg <= inMemtoReg;
      outRegWrite <= inRegWrite;
`ifdef MEM_ALIGN_CHECK_EN
      outMisaligned <= inMisaligned;
`endif
    end
  end

endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access stage of the 5-stage MIPS pipeline.
// Little-endian data memory with byte-lane write masking, combinational
// read, sign/zero load extension and a registered MEM/WB latch.
// Optional MEM_ALIGN_CHECK_EN: flags misaligned accesses, suppresses their
// writes and kills the register write of misaligned loads.
module stage_mem
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] inAlu,
  input  logic [31:0] inDataRt,
  input  logic [4:0]  inMuxRtRd,
  input  logic [1:0]  inMemtoReg,
  input  logic        inRegWrite,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [2:0]  inflagLoadWordDividerMEM,
  input  logic [1:0]  inflagStoreWordDividerMEM,
  output logic [31:0] outMemData,
  output logic [31:0] outAlu,
  output logic [4:0]  outMuxRtRd,
  output logic [1:0]  outMemtoReg,
  output logic        outRegWrite
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        outMisaligned
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           memArray_r [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] wordIdx_s;
  logic [1:0]            byteOff_s;
  logic [31:0]           rdWord_s;
  logic [31:0]           wrData_s;
  logic [3:0]            laneMask_s;
  logic [3:0]            wrLanes_s;
  logic [31:0]           ldData_s;
  logic                  misLoad_s;
  logic                  misStore_s;
  logic                  regWrite_s;
  logic                  unusedAluHigh_s;

  // Address bits above the word index are dropped, so addresses alias.
  assign wordIdx_s       = inAlu[ADDR_WIDTH+1:2];
  assign byteOff_s       = inAlu[1:0];
  assign unusedAluHigh_s = ^inAlu[31:ADDR_WIDTH+2];

  // Read is combinational, so a same-cycle store is not visible to the load.
  assign rdWord_s = memArray_r[wordIdx_s];

  // Lane selection and lane-replicated store data for SW/SH/SB.
  always_comb begin
    laneMask_s = LANE_ALL;
    wrData_s   = inDataRt;
    case (inflagStoreWordDividerMEM)
      ST_SH: begin
        laneMask_s = inAlu[1] ? LANE_HALF_HI : LANE_HALF_LO;
        wrData_s   = {2{inDataRt[15:0]}};
      end
      ST_SB: begin
        laneMask_s = LANE_BYTE0 << byteOff_s;
        wrData_s   = {4{inDataRt[7:0]}};
      end
      default: begin
        laneMask_s = LANE_ALL;
        wrData_s   = inDataRt;
      end
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Misalignment: word accesses need off=0, halfword accesses need off[0]=0.
  always_comb begin
    misLoad_s  = 1'b0;
    misStore_s = 1'b0;
    case (inflagLoadWordDividerMEM)
      LD_LH, LD_LHU: misLoad_s = inMemRead & byteOff_s[0];
      LD_LB, LD_LBU: misLoad_s = 1'b0;
      default:       misLoad_s = inMemRead & (byteOff_s != 2'b00);
    endcase
    case (inflagStoreWordDividerMEM)
      ST_SH:   misStore_s = inMemWrite & byteOff_s[0];
      ST_SB:   misStore_s = 1'b0;
      default: misStore_s = inMemWrite & (byteOff_s != 2'b00);
    endcase
  end
`else
  assign misLoad_s  = 1'b0;
  assign misStore_s = 1'b0;
`endif

  // Write port is gated by stall, reset and a misaligned store.
  always_comb begin
    if (inMemWrite && enable && !reset && !misStore_s) begin
      wrLanes_s = laneMask_s;
    end else begin
      wrLanes_s = LANE_NONE;
    end
  end

  // Data memory: per-lane synchronous write, contents survive reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wrLanes_s[k]) begin
        memArray_r[wordIdx_s][8*k +: 8] <= wrData_s[8*k +: 8];
      end
    end
  end

  // Load data is extended only for real loads; otherwise the latch sees 0.
  always_comb begin
    if (inMemRead) begin
      ldData_s = extendLoad(rdWord_s, inflagLoadWordDividerMEM, byteOff_s);
    end else begin
      ldData_s = 32'h0000_0000;
    end
  end

  assign regWrite_s = inRegWrite & ~misLoad_s;

  mem_wb_latch uLatch (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .inMemData   (ldData_s),
    .inAlu       (inAlu),
    .inMuxRtRd   (inMuxRtRd),
    .inMemtoReg  (inMemtoReg),
    .inRegWrite  (regWrite_s),
    .outMemData  (outMemData),
    .outAlu      (outAlu),
    .outMuxRtRd  (outMuxRtRd),
    .outMemtoReg (outMemtoReg),
    .outRegWrite (outRegWrite)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .inMisaligned  (misLoad_s | misStore_s),
    .outMisaligned (outMisaligned)
`endif
  );

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: self-checking bench for stage_mem.
// Reference model is a flat little-endian byte array; expected MEM/WB
// contents are derived from address arithmetic on that array.
module tb_stage_mem;

  localparam int AW     = 8;
  localparam int NBYTES = 4 << AW;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [31:0] inAlu, inDataRt;
  logic [4:0]  inMuxRtRd;
  logic [1:0]  inMemtoReg;
  logic        inRegWrite, inMemRead, inMemWrite;
  logic [2:0]  inflagLoadWordDividerMEM;
  logic [1:0]  inflagStoreWordDividerMEM;
  logic [31:0] outMemData, outAlu;
  logic [4:0]  outMuxRtRd;
  logic [1:0]  outMemtoReg;
  logic        outRegWrite;
  logic        outMisaligned;

  int vectors    = 0;
  int miscompares = 0;

  logic [7:0]  refMem [NBYTES];
  logic [31:0] expMemData, expAlu;
  logic [4:0]  expRd;
  logic [1:0]  expMtr;
  logic        expRw, expMis;

  always #5 clk = ~clk;

  stage_mem #(.ADDR_WIDTH(AW)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .enable                    (enable),
    .inAlu                     (inAlu),
    .inDataRt                  (inDataRt),
    .inMuxRtRd                 (inMuxRtRd),
    .inMemtoReg                (inMemtoReg),
    .inRegWrite                (inRegWrite),
    .inMemRead                 (inMemRead),
    .inMemWrite                (inMemWrite),
    .inflagLoadWordDividerMEM  (inflagLoadWordDividerMEM),
    .inflagStoreWordDividerMEM (inflagStoreWordDividerMEM),
    .outMemData                (outMemData),
    .outAlu                    (outAlu),
    .outMuxRtRd                (outMuxRtRd),
    .outMemtoReg               (outMemtoReg),
    .outRegWrite               (outRegWrite)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .outMisaligned             (outMisaligned)
`endif
  );

`ifndef MEM_ALIGN_CHECK_EN
  assign outMisaligned = 1'b0;
`endif

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refLoad(input int a, input logic [2:0] ldf);
    int b;
    int v;
    case (ldf)
      3'd1, 3'd2: begin
        b = a - (a % 2);
        v = int'({refMem[b+1], refMem[b]});
        if (ldf == 3'd1 && v >= 32768) v = v - 65536;
      end
      3'd3, 3'd4: begin
        v = int'(refMem[a]);
        if (ldf == 3'd3 && v >= 128) v = v - 256;
      end
      default: begin
        b = a - (a % 4);
        v = int'({refMem[b+3], refMem[b+2], refMem[b+1], refMem[b]});
      end
    endcase
    return 32'(v);
  endfunction

  // One pipeline cycle: drive at negedge, predict, then check after posedge.
  task automatic step(input logic rst, input logic en, input logic [31:0] alu,
                      input logic [31:0] rt, input logic [4:0] rd, input logic [1:0] mtr,
                      input logic rw, input logic mr, input logic mw,
                      input logic [2:0] ldf, input logic [1:0] stf);
    int a;
    int b;
    logic misL, misS;
    logic [31:0] ld;
    @(negedge clk);
    reset = rst; enable = en; inAlu = alu; inDataRt = rt; inMuxRtRd = rd;
    inMemtoReg = mtr; inRegWrite = rw; inMemRead = mr; inMemWrite = mw;
    inflagLoadWordDividerMEM = ldf; inflagStoreWordDividerMEM = stf;
    a = int'(alu[AW+1:0]);
    misL = 1'b0;
    misS = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (mr) begin
      if (ldf == 3'd1 || ldf == 3'd2) misL = (a % 2) != 0;
      else if (ldf == 3'd3 || ldf == 3'd4) misL = 1'b0;
      else misL = (a % 4) != 0;
    end
    if (mw) begin
      if (stf == 2'd1) misS = (a % 2) != 0;
      else if (stf == 2'd2) misS = 1'b0;
      else misS = (a % 4) != 0;
    end
`endif
    ld = refLoad(a, ldf);
    if (rst) begin
      expMemData = 32'h0; expAlu = 32'h0; expRd = 5'd0; expMtr = 2'd0;
      expRw = 1'b0; expMis = 1'b0;
    end else if (en) begin
      expMemData = mr ? ld : 32'h0;
      expAlu = alu; expRd = rd; expMtr = mtr;
      expRw = rw & ~misL;
      expMis = misL | misS;
    end
    if (!rst && en && mw && !misS) begin
      if (stf == 2'd1) begin
        b = a - (a % 2);
        refMem[b] = rt[7:0]; refMem[b+1] = rt[15:8];
      end else if (stf == 2'd2) begin
        refMem[a] = rt[7:0];
      end else begin
        b = a - (a % 4);
        refMem[b] = rt[7:0]; refMem[b+1] = rt[15:8];
        refMem[b+2] = rt[23:16]; refMem[b+3] = rt[31:24];
      end
    end
    @(posedge clk);
    #1;
    checkVal("memData", outMemData, expMemData);
    checkVal("alu", outAlu, expAlu);
    checkVal("rtrd", {27'd0, outMuxRtRd}, {27'd0, expRd});
    checkVal("memtoReg", {30'd0, outMemtoReg}, {30'd0, expMtr});
    checkVal("regWrite", {31'd0, outRegWrite}, {31'd0, expRw});
    checkVal("misaligned", {31'd0, outMisaligned}, {31'd0, expMis});
  endtask

  initial begin
    logic [31:0] alu;
    logic [9:0]  low;
    int op;
    logic mr, mw;

    // Reset two cycles, then fill memory so the model starts fully known.
    step(1'b1, 1'b1, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    step(1'b1, 1'b1, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd0);
    checkVal("reset_memData", outMemData, 32'h0);
    checkVal("reset_regWrite", {31'd0, outRegWrite}, 32'h0);
    for (int i = 0; i < (1 << AW); i++) begin
      step(1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0);
    end

    // SW then LW
    step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0);
    step(1'b0, 1'b1, 32'h10, 32'h0, 5'd8, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    checkVal("lw_deadbeef", outMemData, 32'hDEADBEEF);

    // SB / LB / LBU, neighbouring bytes preserved
    step(1'b0, 1'b1, 32'h13, 32'h80, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd2);
    step(1'b0, 1'b1, 32'h13, 32'h0, 5'd9, 2'd1, 1'b1, 1'b1, 1'b0, 3'd3, 2'd0);
    checkVal("lb_sign", outMemData, 32'hFFFFFF80);
    step(1'b0, 1'b1, 32'h13, 32'h0, 5'd9, 2'd1, 1'b1, 1'b1, 1'b0, 3'd4, 2'd0);
    checkVal("lbu_zero", outMemData, 32'h00000080);
    step(1'b0, 1'b1, 32'h10, 32'h0, 5'd9, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    checkVal("sb_lanes", outMemData, 32'h80ADBEEF);

    // SH / LH / LHU, low lanes preserved
    step(1'b0, 1'b1, 32'h22, 32'h8001, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd1);
    step(1'b0, 1'b1, 32'h22, 32'h0, 5'd10, 2'd1, 1'b1, 1'b1, 1'b0, 3'd1, 2'd0);
    checkVal("lh_sign", outMemData, 32'hFFFF8001);
    step(1'b0, 1'b1, 32'h22, 32'h0, 5'd10, 2'd1, 1'b1, 1'b1, 1'b0, 3'd2, 2'd0);
    checkVal("lhu_zero", outMemData, 32'h00008001);
    step(1'b0, 1'b1, 32'h20, 32'h0, 5'd10, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);

    // Stall: write suppressed and outputs hold, then commit
    step(1'b0, 1'b0, 32'h30, 32'h12345678, 5'd3, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0);
    checkVal("stall_hold_alu", outAlu, 32'h20);
    step(1'b0, 1'b1, 32'h30, 32'h0, 5'd4, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    step(1'b0, 1'b1, 32'h30, 32'h12345678, 5'd3, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0);
    step(1'b0, 1'b1, 32'h30, 32'h0, 5'd4, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    checkVal("stall_commit", outMemData, 32'h12345678);

    // Aliasing above the word index
    step(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0);
    step(1'b0, 1'b1, 32'h000, 32'h0, 5'd5, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    checkVal("alias", outMemData, 32'hA5A5A5A5);

    // Illegal read+write returns the pre-write word
    step(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 5'd6, 2'd1, 1'b1, 1'b1, 1'b1, 3'd0, 2'd0);
    step(1'b0, 1'b1, 32'h40, 32'h0, 5'd6, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    checkVal("rw_commit", outMemData, 32'hCAFEF00D);

    // Reset mid-stream drops the store
    step(1'b1, 1'b1, 32'h50, 32'h55AA55AA, 5'd7, 2'd0, 1'b1, 1'b0, 1'b1, 3'd0, 2'd0);
    step(1'b0, 1'b1, 32'h50, 32'h0, 5'd7, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);

`ifdef MEM_ALIGN_CHECK_EN
    step(1'b0, 1'b1, 32'h11, 32'h0, 5'd2, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    checkVal("mis_flag", {31'd0, outMisaligned}, 32'h1);
    checkVal("mis_rw", {31'd0, outRegWrite}, 32'h0);
    step(1'b0, 1'b1, 32'h12, 32'h11111111, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd0);
    step(1'b0, 1'b1, 32'h10, 32'h0, 5'd2, 2'd1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0);
    checkVal("mis_nowrite", outMemData, 32'h80ADBEEF);
`endif

    // Randomized traffic concentrated on a few words
    for (int i = 0; i < 400; i++) begin
      alu = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        low = 10'($urandom_range(0, 31));
        alu[AW+1:0] = low;
      end
      op = $urandom_range(0, 7);
      mr = (op < 3) || (op == 7);
      mw = (op >= 3 && op < 6) || (op == 7);
      step(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
           alu, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), mr, mw,
           3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
